// File: rtl/alu_pkg.sv
// Shared opcode encodings, default widths and the response record for the ALU responder.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 4;
  localparam int unsigned ALU_TAG_W = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] result;
    logic                 carr;
    logic                 zero;
    logic [ALU_TAG_W-1:0] tag;
  } alu_rsp_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result, carry/borrow/shifted-out bit and zero flag for one opcode.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carr,
  output logic             zero
);

  // b is referenced only in the branches that use it, so unknowns on b
  // cannot leak into NOT/shift results.
  always_comb begin
    result = '0;
    carr   = 1'b0;
    case (alu_op_e'(op))
      OP_ADD:  {carr, result} = {1'b0, a} + {1'b0, b};
      OP_SUB:  {carr, result} = {1'b0, a} - {1'b0, b};
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_SHL:  begin
        result = a << 1;
        carr   = a[WIDTH-1];
      end
      OP_SHR:  begin
        result = a >> 1;
        carr   = a[0];
      end
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_resp_unit.sv
// Handshaked ALU responder: request port -> alu_core -> small output FIFO -> response port.
// Optional accumulator operand source enabled by defining ALU_ACC_EN.
module alu_resp_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned TAG_W = 3,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
`ifdef ALU_ACC_EN
  input  logic             req_acc,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carr,
  output logic             rsp_zero,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [CNT_W-1:0] rsp_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {OCC_EMPTY, OCC_PARTIAL, OCC_FULL} occ_state_e;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carr;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } entry_t;

  occ_state_e       state, state_nxt;
  logic [OCC_W-1:0] occ, occ_nxt;
  logic [PTR_W-1:0] wptr, rptr, rptr_nxt;
  entry_t           mem [DEPTH];
  entry_t           head_q, head_nxt, new_entry;
  logic             push, pop, head_is_new;

  logic [WIDTH-1:0] a_eff, core_result;
  logic             core_carr, core_zero;

  assign rsp_valid = (state != OCC_EMPTY);
  assign pop       = rsp_valid & rsp_ready;
  assign req_ready = (state != OCC_FULL) | pop;
  assign push      = req_valid & req_ready;

`ifdef ALU_ACC_EN
  logic [WIDTH-1:0] acc;

  assign a_eff = req_acc ? acc : req_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    acc <= '0;
    else if (push) acc <= core_result;
  end
`else
  assign a_eff = req_a;
`endif

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (a_eff),
    .b      (req_b),
    .op     (req_op),
    .result (core_result),
    .carr   (core_carr),
    .zero   (core_zero)
  );

  assign new_entry = '{result: core_result, carr: core_carr, zero: core_zero, tag: req_tag};

  always_comb begin
    occ_nxt = occ;
    case ({push, pop})
      2'b10:   occ_nxt = occ + OCC_W'(1);
      2'b01:   occ_nxt = occ - OCC_W'(1);
      default: occ_nxt = occ;
    endcase

    if (occ_nxt == '0)                 state_nxt = OCC_EMPTY;
    else if (occ_nxt == OCC_W'(DEPTH)) state_nxt = OCC_FULL;
    else                               state_nxt = OCC_PARTIAL;

    rptr_nxt = pop ? rptr + PTR_W'(1) : rptr;

    // The head register is refilled one cycle ahead: from the incoming request
    // when it becomes the oldest entry, otherwise from the next stored slot.
    head_is_new = push && ((occ == '0) || (pop && (occ == OCC_W'(1))));
    head_nxt    = head_q;
    if (occ_nxt != '0)
      head_nxt = head_is_new ? new_entry : mem[rptr_nxt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= OCC_EMPTY;
      occ       <= '0;
      wptr      <= '0;
      rptr      <= '0;
      head_q    <= '0;
      rsp_count <= '0;
    end else begin
      state  <= state_nxt;
      occ    <= occ_nxt;
      rptr   <= rptr_nxt;
      head_q <= head_nxt;
      if (push) wptr      <= wptr + PTR_W'(1);
      if (pop)  rsp_count <= rsp_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= new_entry;
  end

  assign rsp_result = head_q.result;
  assign rsp_carr   = head_q.carr;
  assign rsp_zero   = head_q.zero;
  assign rsp_tag    = head_q.tag;

endmodule

// File: tb/tb_alu_resp_unit.sv
// Directed self-checking bench for alu_resp_unit (default configuration).
module tb_alu_resp_unit;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic [2:0] req_op;
  logic [2:0] req_tag;
`ifdef ALU_ACC_EN
  logic       req_acc;
`endif
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_carr;
  logic       rsp_zero;
  logic [2:0] rsp_tag;
  logic [7:0] rsp_count;

  int checks = 0;
  int errors = 0;
  alu_rsp_t exp_q[$];

  always #5 clk = ~clk;

  alu_resp_unit #(.WIDTH(4), .TAG_W(3), .DEPTH(2), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .req_tag    (req_tag),
`ifdef ALU_ACC_EN
    .req_acc    (req_acc),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carr   (rsp_carr),
    .rsp_zero   (rsp_zero),
    .rsp_tag    (rsp_tag),
    .rsp_count  (rsp_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_head(input string tag, input alu_rsp_t e);
    check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".res"},   32'(rsp_result), 32'(e.result));
    check({tag, ".carr"},  32'(rsp_carr), 32'(e.carr));
    check({tag, ".zero"},  32'(rsp_zero), 32'(e.zero));
    check({tag, ".tag"},   32'(rsp_tag), 32'(e.tag));
  endtask

  // One request with the consumer always ready; result is checked right after the accepting edge.
  task automatic do_op(input string name, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input logic [2:0] tag,
                       input logic [3:0] er, input logic ec, input logic ez);
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_a = a; req_b = b; req_op = op; req_tag = tag;
    #1 check({name, ".rdy"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_b = 'x;
    check_head(name, '{result: er, carr: ec, zero: ez, tag: tag});
  endtask

  // Drives one add request and records its expected response.
  task automatic offer_add(input logic [3:0] a, input logic [3:0] b, input logic [2:0] tag);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    req_valid = 1'b1;
    req_a = a; req_b = b; req_op = OP_ADD; req_tag = tag;
    exp_q.push_back('{result: s[3:0], carr: s[4], zero: (s[3:0] == 4'd0), tag: tag});
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0; req_tag = '0;
`ifdef ALU_ACC_EN
    req_acc = 1'b0;
`endif
    #2;
    check("rst.valid", 32'(rsp_valid), 32'd0);
    check("rst.res",   32'(rsp_result), 32'd0);
    check("rst.tag",   32'(rsp_tag), 32'd0);
    check("rst.count", 32'(rsp_count), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    do_op("add",   4'b0011, 4'b0101, OP_ADD, 3'd1, 4'b1000, 1'b0, 1'b0);
    do_op("add0",  4'b0000, 4'b0000, OP_ADD, 3'd2, 4'b0000, 1'b0, 1'b1);
    do_op("sub",   4'b0110, 4'b0011, OP_SUB, 3'd3, 4'b0011, 1'b0, 1'b0);
    do_op("subbw", 4'b0011, 4'b0110, OP_SUB, 3'd4, 4'b1101, 1'b1, 1'b0);
    do_op("and",   4'b1101, 4'b1011, OP_AND, 3'd5, 4'b1001, 1'b0, 1'b0);
    do_op("or",    4'b1101, 4'b1011, OP_OR,  3'd6, 4'b1111, 1'b0, 1'b0);
    do_op("xor",   4'b1101, 4'b1011, OP_XOR, 3'd7, 4'b0110, 1'b0, 1'b0);
    do_op("not",   4'b1101, 4'bxxxx, OP_NOT, 3'd0, 4'b0010, 1'b0, 1'b0);
    do_op("shl",   4'b1010, 4'bxxxx, OP_SHL, 3'd1, 4'b0100, 1'b1, 1'b0);
    do_op("shr",   4'b1010, 4'bxxxx, OP_SHR, 3'd2, 4'b0101, 1'b0, 1'b0);
    @(posedge clk);
    #1 check("ops.count", 32'(rsp_count), 32'd10);
    check("ops.empty", 32'(rsp_valid), 32'd0);

    // Backpressure: two fit, the third stalls until the consumer drains.
    @(negedge clk);
    rsp_ready = 1'b0;
    offer_add(4'd1, 4'd1, 3'd1);
    #1 check("bp.rdy1", 32'(req_ready), 32'd1);
    @(negedge clk);
    offer_add(4'd2, 4'd2, 3'd2);
    #1 check("bp.rdy2", 32'(req_ready), 32'd1);
    check_head("bp.h1a", exp_q[0]);
    @(negedge clk);
    offer_add(4'd3, 4'd3, 3'd3);
    #1 check("bp.rdy3", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 check_head("bp.h1b", exp_q[0]);
    @(negedge clk);
    rsp_ready = 1'b1;
    #1 check("bp.rdy3p", 32'(req_ready), 32'd1);
    void'(exp_q.pop_front());
    @(posedge clk);
    #1 req_valid = 1'b0;
    check_head("bp.h2", exp_q.pop_front());
    @(posedge clk);
    #1 check_head("bp.h3", exp_q.pop_front());
    @(posedge clk);
    #1 check("bp.empty", 32'(rsp_valid), 32'd0);
    check("bp.count", 32'(rsp_count), 32'd13);

    // Fill to full, then stream with simultaneous push and pop.
    @(negedge clk) rsp_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      offer_add(4'(14 + k), 4'd1, 3'(4 + k));
      #1 check("full.fill.rdy", 32'(req_ready), 32'd1);
      @(negedge clk);
    end
    req_valid = 1'b0;
    #1 check("full.rdy0", 32'(req_ready), 32'd0);
    for (int i = 0; i < 20; i++) begin
      rsp_ready = 1'b1;
      #1 check("stream.rdy", 32'(req_ready), 32'd1);
      check_head("stream", exp_q.pop_front());
      offer_add(4'(i), 4'd3, 3'(i));
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int j = 0; j < 4 && exp_q.size() > 0; j++) begin
      #1 check_head("drain", exp_q.pop_front());
      @(negedge clk);
    end
    #1 check("stream.empty", 32'(rsp_valid), 32'd0);
    check("stream.count", 32'(rsp_count), 32'd35);

    // Asynchronous reset with two entries queued.
    @(negedge clk) rsp_ready = 1'b0;
    offer_add(4'd5, 4'd5, 3'd5);
    @(negedge clk);
    offer_add(4'd6, 4'd6, 3'd6);
    @(negedge clk);
    req_valid = 1'b0;
    #1 check("mr.full", 32'(req_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1 check("mr.valid", 32'(rsp_valid), 32'd0);
    check("mr.count", 32'(rsp_count), 32'd0);
    check("mr.res", 32'(rsp_result), 32'd0);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
`ifdef ALU_ACC_EN
    req_acc = 1'b1;
    do_op("acc", 4'b1111, 4'b0001, OP_ADD, 3'd3, 4'b0001, 1'b0, 1'b0);
    req_acc = 1'b0;
`else
    do_op("post", 4'b0011, 4'b0101, OP_ADD, 3'd3, 4'b1000, 1'b0, 1'b0);
`endif
    @(posedge clk);
    #1 check("post.count", 32'(rsp_count), 32'd1);
    check("post.empty", 32'(rsp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
